// File: rtl/obi_mem_arbiter_pkg.sv
// Shared types and helpers for the OBI instruction/data to single-port SRAM arbiter.
package obi_arb_pkg;

    typedef enum logic [2:0] {
        RESP_NONE,
        RESP_MEM_I,
        RESP_MEM_D,
        RESP_ERR_I,
        RESP_ERR_D
    } resp_owner_e;

    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // Address falls inside the SRAM window; mem_size must be a power of two.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] mem_start,
                                      input logic [31:0] mem_size);
        return (addr & ~(mem_size - 32'd1)) == mem_start;
    endfunction

endpackage

// File: rtl/obi_mem_arbiter.sv
// Arbitrates the core's instruction and data OBI ports onto one single-port SRAM
// and steers each one-cycle-latency response back to the channel that owns it.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE     = 8192,
    parameter logic [31:0] MEM_START    = 32'h0000_0000,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        proto_err_o
);

    localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);
    localparam logic [2:0]  STARVE_MAX = 3'(STARVE_LIMIT);

    resp_owner_e resp_q, resp_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic        proto_err_q, proto_err_d;

    logic data_wins;
    logic instr_in, data_in;
    logic resp_is_mem;

    always_comb begin
        // Data goes first when instruction is idle or data has waited long enough.
        data_wins   = data_req_i && (!instr_req_i || (starve_cnt_q == STARVE_MAX));
        instr_gnt_o = !rst_i && instr_req_i && !data_wins;
        data_gnt_o  = !rst_i && data_wins;
        instr_in    = in_range(instr_addr_i, MEM_START, MEM_SIZE_W);
        data_in     = in_range(data_addr_i, MEM_START, MEM_SIZE_W);

        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        resp_d      = RESP_NONE;

        if (instr_gnt_o) begin
            resp_d = instr_in ? RESP_MEM_I : RESP_ERR_I;
            if (instr_in) begin
                mem_req_o  = 1'b1;
                mem_be_o   = 4'hF;
                mem_addr_o = instr_addr_i;
            end
        end else if (data_gnt_o) begin
            resp_d = data_in ? RESP_MEM_D : RESP_ERR_D;
            if (data_in) begin
                mem_req_o   = 1'b1;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
        end

        starve_cnt_d = 3'd0;
        if (data_req_i && !data_gnt_o) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 3'd1;
        end

        resp_is_mem = (resp_q == RESP_MEM_I) || (resp_q == RESP_MEM_D);
        proto_err_d = proto_err_q
                    || (mem_rvalid_i && !resp_is_mem)
                    || (resp_is_mem && !mem_rvalid_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q       <= RESP_NONE;
            starve_cnt_q <= 3'd0;
            proto_err_q  <= 1'b0;
        end else begin
            resp_q       <= resp_d;
            starve_cnt_q <= starve_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Responses are silenced while reset is held so nothing outstanding leaks out.
    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = 32'h0;
        instr_err_o    = 1'b0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = 32'h0;
        data_err_o     = 1'b0;
        if (!rst_i) begin
            unique case (resp_q)
                RESP_MEM_I: begin
                    instr_rvalid_o = mem_rvalid_i;
                    instr_rdata_o  = mem_rdata_i;
                end
                RESP_MEM_D: begin
                    data_rvalid_o = mem_rvalid_i;
                    data_rdata_o  = mem_rdata_i;
                end
                RESP_ERR_I: begin
                    instr_rvalid_o = 1'b1;
                    instr_err_o    = 1'b1;
                end
                RESP_ERR_D: begin
                    data_rvalid_o = 1'b1;
                    data_err_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed scoreboard bench for obi_mem_arbiter with a one-cycle SRAM responder model.
module tb_obi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        proto_err_o;

    logic        mem_rvalid_q = 1'b0;
    logic [31:0] mem_rdata_q = '0;
    logic [31:0] rd_next = '0;
    logic        inject = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit exp_proto = 1'b0;

    typedef struct {
        int          due;
        bit          ch;
        bit          err;
        logic [31:0] rdata;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rvalid_q <= mem_req_o;
        mem_rdata_q  <= mem_req_o ? rd_next : 32'h0;
    end
    assign mem_rvalid_i = mem_rvalid_q | inject;
    assign mem_rdata_i  = mem_rdata_q;

    obi_mem_arbiter #(.MEM_SIZE(8192), .MEM_START(32'h0), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .proto_err_o(proto_err_o)
    );

    function automatic bit model_in_range(input logic [31:0] a);
        return (a & 32'hFFFF_E000) == 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_resp();
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("instr_rvalid", 32'(instr_rvalid_o), 32'(e.ch == 1'b0));
            check("instr_err", 32'(instr_err_o), 32'(e.ch == 1'b0 && e.err));
            check("instr_rdata", instr_rdata_o, (e.ch == 1'b0) ? e.rdata : 32'h0);
            check("data_rvalid", 32'(data_rvalid_o), 32'(e.ch == 1'b1));
            check("data_err", 32'(data_err_o), 32'(e.ch == 1'b1 && e.err));
            check("data_rdata", data_rdata_o, (e.ch == 1'b1) ? e.rdata : 32'h0);
        end else begin
            check("instr_rvalid_idle", 32'(instr_rvalid_o), 32'h0);
            check("data_rvalid_idle", 32'(data_rvalid_o), 32'h0);
        end
    endtask

    task automatic step(input bit ireq, input logic [31:0] iaddr,
                        input bit dreq, input bit dwe, input logic [3:0] dbe,
                        input logic [31:0] daddr, input logic [31:0] dwd,
                        input logic [31:0] rd, input bit eig, input bit edg);
        bit inr;
        @(negedge clk);
        instr_req_i = ireq; instr_addr_i = iaddr;
        data_req_i = dreq; data_we_i = dwe; data_be_i = dbe;
        data_addr_i = daddr; data_wdata_i = dwd;
        rd_next = rd;
        #1;
        check_resp();
        check("proto_err", 32'(proto_err_o), 32'(exp_proto));
        check("instr_gnt", 32'(instr_gnt_o), 32'(eig));
        check("data_gnt", 32'(data_gnt_o), 32'(edg));
        if (eig) begin
            inr = model_in_range(iaddr);
            check("mem_req_i", 32'(mem_req_o), 32'(inr));
            if (inr) begin
                check("mem_addr_i", mem_addr_o, iaddr);
                check("mem_we_i", 32'(mem_we_o), 32'h0);
                check("mem_be_i", 32'(mem_be_o), 32'hF);
            end
            q.push_back('{due: cyc + 1, ch: 1'b0, err: !inr, rdata: inr ? rd : 32'h0});
        end else if (edg) begin
            inr = model_in_range(daddr);
            check("mem_req_d", 32'(mem_req_o), 32'(inr));
            if (inr) begin
                check("mem_addr_d", mem_addr_o, daddr);
                check("mem_we_d", 32'(mem_we_o), 32'(dwe));
                check("mem_be_d", 32'(mem_be_o), 32'(dbe));
                check("mem_wdata_d", mem_wdata_o, dwd);
            end
            q.push_back('{due: cyc + 1, ch: 1'b1, err: !inr, rdata: inr ? rd : 32'h0});
        end else begin
            check("mem_req_idle", 32'(mem_req_o), 32'h0);
            check("mem_addr_idle", mem_addr_o, 32'h0);
        end
        cyc++;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("rst_instr_gnt", 32'(instr_gnt_o), 32'h0);
        check("rst_data_gnt", 32'(data_gnt_o), 32'h0);
        check("rst_mem_req", 32'(mem_req_o), 32'h0);
        check("rst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("rst_data_rvalid", 32'(data_rvalid_o), 32'h0);
        q.delete();
        exp_proto = 1'b0;
        cyc++;
        @(negedge clk);
        rst_i = 1'b0;
        instr_req_i = 1'b0;
        data_req_i = 1'b0;
        cyc++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        idle();
        check("reset_proto_err", 32'(proto_err_o), 32'h0);
        check("reset_instr_rdata", instr_rdata_o, 32'h0);

        // Starvation: four denials, then data forced ahead; counter restarts afterwards.
        for (int i = 0; i < 4; i++)
            step(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'h0, 32'h1000_0000 + i, 1, 0);
        step(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'h0, 32'h2000_0000, 0, 1);
        for (int i = 0; i < 4; i++)
            step(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'h0, 32'h3000_0000 + i, 1, 0);
        step(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'h0, 32'h4000_0000, 0, 1);

        // Dropping data_req clears the count: three denials, a gap, then four more needed.
        for (int i = 0; i < 3; i++)
            step(1, 32'h84, 1, 0, 4'hF, 32'h104, 32'h0, 32'h5000_0000 + i, 1, 0);
        step(1, 32'h84, 0, 0, 4'hF, 32'h104, 32'h0, 32'h5100_0000, 1, 0);
        for (int i = 0; i < 4; i++)
            step(1, 32'h84, 1, 0, 4'hF, 32'h104, 32'h0, 32'h5200_0000 + i, 1, 0);
        step(1, 32'h84, 1, 0, 4'hF, 32'h104, 32'h0, 32'h5300_0000, 0, 1);
        idle();

        step(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1, 0);
        idle();
        step(0, 32'h0, 1, 1, 4'b0011, 32'h0FFC, 32'h1234_5678, 32'h0BAD_F00D, 0, 1);
        idle();
        step(0, 32'h0, 1, 0, 4'hF, 32'h0001_0000, 32'h0, 32'h7777_7777, 0, 1);
        idle();
        step(1, 32'h2000, 0, 0, 4'h0, 32'h0, 32'h0, 32'h6666_6666, 1, 0);
        step(0, 32'h0, 1, 0, 4'hF, 32'h1FFC, 32'h0, 32'hCAFE_0001, 0, 1);
        idle();

        // Back-to-back pipelined grants alternating channels.
        step(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hA000_0000, 1, 0);
        step(0, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0, 32'hA000_0004, 0, 1);
        step(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0, 32'hA000_0008, 1, 0);
        idle();

        // Reset right after a grant drops the outstanding response.
        step(1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0, 32'hB000_0000, 1, 0);
        reset_cycle();
        idle();

        // Unexpected SRAM response sets the sticky protocol error.
        @(negedge clk);
        inject = 1'b1;
        #1;
        check("inj_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("inj_data_rvalid", 32'(data_rvalid_o), 32'h0);
        check("inj_proto_before", 32'(proto_err_o), 32'h0);
        cyc++;
        @(negedge clk);
        inject = 1'b0;
        cyc++;
        exp_proto = 1'b1;
        check("proto_err_set", 32'(proto_err_o), 32'h1);
        idle();
        step(1, 32'h30, 0, 0, 4'h0, 32'h0, 32'h0, 32'hC000_0000, 1, 0);
        idle();
        idle();
        reset_cycle();
        idle();
        check("proto_err_cleared", 32'(proto_err_o), 32'h0);
        check("scoreboard_empty", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Sits between the core's instruction and data request ports and the single-port SRAM (ram_1p). It replaces ad-hoc arbitration glue.
- Arbitrates the two request/grant channels onto one memory port, using instruction priority with data-starvation protection.
- Routes each one-cycle-latency memory response back to its owner. Out-of-range accesses are answered with an error response instead of reaching the SRAM.

Parameters:
- MEM_SIZE, 8192, SRAM size in bytes; power of two.
- MEM_START, 32'h00000000, SRAM base address; aligned to MEM_SIZE.
- STARVE_LIMIT, 4, consecutive cycles a pending data request may be denied before it is forced ahead of instruction.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- instr_req_i  in  1  instruction request
- instr_addr_i  in  32  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  32  instruction read data
- instr_err_o  out  1  instruction error (valid with rvalid)
- data_req_i  in  1  data request
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data error (valid with rvalid)
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  32  SRAM address
- mem_wdata_o  out  32  SRAM write data
- mem_rvalid_i  in  1  SRAM response valid, one cycle after mem_req_o
- mem_rdata_i  in  32  SRAM read data
- proto_err_o  out  1  sticky flag: unexpected or missing mem_rvalid_i

Behaviour:
- Grant timing:
  - Grants are combinational, in the same cycle as the request.
  - At most one grant per cycle.
  - A new grant is allowed every cycle, so back-to-back accesses are pipelined.
- Priority:
  - Instruction wins by default.
  - Data wins if starve_cnt == STARVE_LIMIT.
  - starve_cnt (3 bits, saturating at STARVE_LIMIT):
    - increments when data_req_i=1 and data is not granted;
    - clears on a data grant or when data_req_i=0.
- In-range check: (addr & ~(MEM_SIZE-1)) == MEM_START.
  - In-range grant: mem_req_o=1. mem_* are driven from the winning channel; mem_we_o is 0 for instruction; mem_be_o is 4'hF for instruction.
  - Out-of-range grant: still granted, but mem_req_o=0.
- No grant: mem_req_o=0; all mem_* outputs are 0.
- Response owner register resp_q, enum {NONE, MEM_I, MEM_D, ERR_I, ERR_D}:
  - Loaded at each clock edge from the current cycle's grant; NONE if no grant.
- Responses, in the cycle after the grant:
  - MEM_I: instr_rvalid_o = mem_rvalid_i; instr_rdata_o = mem_rdata_i.
  - MEM_D: same mapping on the data channel; writes also get rvalid.
  - ERR_I / ERR_D: rvalid=1, err=1, rdata=0 on the owning channel; SRAM is ignored.
  - Non-owner channel: rvalid=0, err=0, rdata=0.
- Simultaneous events: a response for grant N and a new grant N+1 in the same cycle are fully supported.
- proto_err_o:
  - Sets when mem_rvalid_i=1 and resp_q is not MEM_*.
  - Sets when resp_q is MEM_* and mem_rvalid_i=0.
  - Cleared only by reset.
- Reset (rst_i=1 at a clock edge):
  - resp_q=NONE, starve_cnt=0, proto_err_o=0.
  - Any outstanding response is dropped: no rvalid in the cycle after reset.
  - While rst_i=1, all gnt/mem_req outputs are forced to 0.
- Reset values of all outputs: 0.

Decomposition:
- Package obi_arb_pkg holds:
  - resp_owner_e enum;
  - function in_range(addr, MEM_START, MEM_SIZE);
  - default STARVE_LIMIT constant.
- No sub-module; the starvation counter and response register live inline.

Test Plan:
- instr_req=1 @0x80 and data_req=1 @0x100 held, data denied 4 cycles -> 5th cycle data_gnt=1, instr_gnt=0; starve_cnt returns to 0.
- instr read @0x10, mem_rdata=32'hDEADBEEF next cycle -> instr_rvalid=1, rdata=DEADBEEF, err=0; data channel quiet.
- data write @0x0FFC be=4'b0011 -> mem_we=1, mem_be=0011, mem_addr=0x0FFC; data_rvalid=1 next cycle.
- data read @0x00010000 (out of range) -> data_gnt=1, mem_req=0; next cycle data_rvalid=1, err=1, rdata=0.
- back-to-back instr @0x0, data @0x4, instr @0x8 -> three grants on consecutive cycles, three responses on the correct channels one cycle later.
- rst_i=1 in cycle right after a grant -> no rvalid that cycle; starve_cnt=0; mem_rvalid_i=1 injected with resp_q=NONE -> proto_err_o=1 sticky until reset.
